// File: rtl/storeq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : storeq_ctl
// Description : Store-queue control. Circular head/tail allocation and
//               in-order reclamation of entries, plus oldest-first
//               (rotate-by-head) arbitration of entry mem-pipe requests.
// Revision    : 1.0 - initial release
// ============================================================================
module storeq_ctl #(
  parameter int NUM_ENTRIES = 8,
  parameter int ID_W        = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_req_mm0,
  output logic                   alloc_gnt_mm0,
  output logic [ID_W-1:0]        alloc_id_mm0,
  output logic [NUM_ENTRIES-1:0] e_alloc_mm0,
  input  logic [NUM_ENTRIES-1:0] e_valid,
  input  logic [NUM_ENTRIES-1:0] e_pipe_req_mm0,
  output logic [NUM_ENTRIES-1:0] e_pipe_gnt_mm0,
  output logic                   stq_pipe_req_mm0,
  output logic [ID_W-1:0]        stq_pipe_id_mm0,
  input  logic                   stq_pipe_gnt_mm0,
  output logic                   full,
  output logic                   empty,
  output logic [ID_W:0]          count
);

  localparam logic [ID_W:0]        FULL_CNT = (ID_W+1)'(NUM_ENTRIES);
  localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);

  // Pointers carry an extra MSB as the wrap bit so full and empty differ.
  logic [ID_W:0]          head_q, head_d;
  logic [ID_W:0]          tail_q, tail_d;
  logic [ID_W-1:0]        head_idx;
  logic [ID_W-1:0]        tail_idx;
  logic                   reclaim;
  logic [NUM_ENTRIES-1:0] req_rot;
  logic [ID_W-1:0]        win_off;
  logic [ID_W-1:0]        win_id;

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];

  // Occupancy, allocation grant and in-order reclaim; next pointer values.
  always_comb begin
    count         = tail_q - head_q;
    full          = (count == FULL_CNT);
    empty         = (count == '0);
    // Refuse while full even if head reclaims this cycle (no bypass).
    alloc_gnt_mm0 = alloc_req_mm0 & ~full & ~reset;
    alloc_id_mm0  = tail_idx;
    e_alloc_mm0   = alloc_gnt_mm0 ? (ONE_HOT0 << tail_idx) : '0;
    // Only the head can retire; idle entries behind it wait their turn.
    reclaim       = ~empty & ~e_valid[head_idx];
    tail_d        = tail_q + {{ID_W{1'b0}}, alloc_gnt_mm0};
    head_d        = head_q + {{ID_W{1'b0}}, reclaim};
  end

  // Oldest-first arbitration: rotate requests so head sits at bit 0, take
  // the lowest set bit, then rotate the offset back into an entry id.
  always_comb begin
    req_rot = '0;
    win_off = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      req_rot[i] = e_pipe_req_mm0[head_idx + ID_W'(i)];
    end
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (req_rot[i]) win_off = ID_W'(i);
    end
    win_id           = head_idx + win_off;
    stq_pipe_req_mm0 = |e_pipe_req_mm0;
    stq_pipe_id_mm0  = stq_pipe_req_mm0 ? win_id : '0;
    e_pipe_gnt_mm0   = (stq_pipe_gnt_mm0 & stq_pipe_req_mm0) ?
                       (ONE_HOT0 << win_id) : '0;
  end

  // Pointer registers; cleared asynchronously so reset takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  a_alloc_free_entry: assert property (@(posedge clk) disable iff (reset)
    (e_alloc_mm0 & e_valid) == '0);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(e_pipe_gnt_mm0));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= FULL_CNT);
  a_req_from_valid: assert property (@(posedge clk) disable iff (reset)
    (e_pipe_req_mm0 & ~e_valid) == '0);

endmodule
`default_nettype wire

// File: tb/tb_storeq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_storeq_ctl
// Description : Directed self-checking bench for storeq_ctl. A queue model
//               using unbounded integer head/tail counters predicts every
//               output; literal checks pin key points of the scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_storeq_ctl;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [2:0]   alloc_id;
  logic [N-1:0] e_alloc;
  logic [N-1:0] e_valid;
  logic [N-1:0] e_pipe_req;
  logic [N-1:0] e_pipe_gnt;
  logic         stq_pipe_req;
  logic [2:0]   stq_pipe_id;
  logic         stq_pipe_gnt;
  logic         full;
  logic         empty;
  logic [3:0]   count;

  int tests = 0;
  int fails = 0;
  // Model: total entries ever allocated (tl) and ever reclaimed (hd).
  int hd = 0;
  int tl = 0;

  storeq_ctl #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .alloc_req_mm0(alloc_req), .alloc_gnt_mm0(alloc_gnt),
    .alloc_id_mm0(alloc_id), .e_alloc_mm0(e_alloc),
    .e_valid(e_valid), .e_pipe_req_mm0(e_pipe_req),
    .e_pipe_gnt_mm0(e_pipe_gnt), .stq_pipe_req_mm0(stq_pipe_req),
    .stq_pipe_id_mm0(stq_pipe_id), .stq_pipe_gnt_mm0(stq_pipe_gnt),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    return tl - hd;
  endfunction

  function automatic bit m_gnt();
    return alloc_req && (m_cnt() != N) && !reset;
  endfunction

  // First requester found walking from the oldest entry; -1 if none.
  function automatic int m_win();
    for (int k = 0; k < N; k++)
      if (e_pipe_req[(hd + k) % N]) return (hd + k) % N;
    return -1;
  endfunction

  // One clock: model state advances with the edge; allocated entries
  // raise their valid one cycle after the grant, as an entry FSM would.
  task automatic tick();
    bit g;
    bit r;
    int id;
    @(posedge clk);
    g  = m_gnt();
    id = tl % N;
    r  = (m_cnt() > 0) && !e_valid[hd % N] && !reset;
    #1;
    if (!reset) begin
      if (g) begin
        tl++;
        e_valid[id] = 1'b1;
      end
      if (r) hd++;
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int w;
    w = m_win();
    chk("alloc_gnt", alloc_gnt, m_gnt());
    if (m_gnt()) chk("alloc_id", alloc_id, tl % N);
    chk("e_alloc", e_alloc, m_gnt() ? (1 << (tl % N)) : 0);
    chk("stq_pipe_req", stq_pipe_req, w >= 0);
    chk("stq_pipe_id", stq_pipe_id, (w >= 0) ? w : 0);
    chk("e_pipe_gnt", e_pipe_gnt, (stq_pipe_gnt && w >= 0) ? (1 << w) : 0);
    chk("full", full, m_cnt() == N);
    chk("empty", empty, m_cnt() == 0);
    chk("count", count, m_cnt());
  end

  initial begin
    reset = 1'b1; alloc_req = 1'b1; e_valid = '0;
    e_pipe_req = '0; stq_pipe_gnt = 1'b0;

    // Reset state: requests ignored while reset is high.
    tick(); tick();
    #1;
    chk("rst_alloc_gnt", alloc_gnt, 0);
    chk("rst_e_alloc", e_alloc, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    reset = 1'b0;

    // Eight back-to-back allocations fill the queue.
    for (int i = 0; i < N; i++) begin
      #1; chk("fill_id", alloc_id, i);
      tick();
    end
    #1;
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("ninth_refused", alloc_gnt, 0);
    tick();

    // Head reclaims while full: same-cycle alloc refused, next one wraps to 0.
    e_valid[0] = 1'b0;
    #1; chk("no_bypass", alloc_gnt, 0);
    tick();
    #1;
    chk("reclaim_count", count, 7);
    chk("wrap_gnt", alloc_gnt, 1);
    chk("wrap_id", alloc_id, 0);
    tick();
    alloc_req = 1'b0;
    #1; chk("refill_count", count, 8);

    // Out-of-order idle: entry 3 idles while head entry 1 is still valid.
    e_valid[3] = 1'b0;
    tick(); tick();
    #1; chk("ooo_hold", count, 8);
    e_valid[1] = 1'b0; e_valid[2] = 1'b0;
    tick(); #1; chk("ooo_c1", count, 7);
    tick(); #1; chk("ooo_c2", count, 6);
    tick(); #1; chk("ooo_c3", count, 5);
    tick(); #1; chk("ooo_stop", count, 5);

    // Simultaneous alloc (id 1) and reclaim (entry 4): count unchanged.
    e_valid[4] = 1'b0; alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    #1; chk("simul5_count", count, 5);

    // Arbitration with head=5.
    e_pipe_req = 8'h42; stq_pipe_gnt = 1'b1;
    #1;
    chk("arb_id", stq_pipe_id, 6);
    chk("arb_gnt", e_pipe_gnt, 8'h40);
    stq_pipe_gnt = 1'b0;
    #1;
    chk("arb_nogrant", e_pipe_gnt, 0);
    chk("arb_req", stq_pipe_req, 1);
    tick();
    e_pipe_req = 8'h02; stq_pipe_gnt = 1'b1;
    #1;
    chk("arb_wrap_id", stq_pipe_id, 1);
    chk("arb_wrap_gnt", e_pipe_gnt, 8'h02);
    e_pipe_req = 8'h21;
    #1; chk("arb_head_id", stq_pipe_id, 5);
    tick();
    e_pipe_req = 8'h00;
    #1;
    chk("arb_none_id", stq_pipe_id, 0);
    chk("arb_none_gnt", e_pipe_gnt, 0);
    stq_pipe_gnt = 1'b0;
    tick();

    // Drain to count=3, then simultaneous alloc and reclaim.
    e_valid[5] = 1'b0; tick();
    e_valid[6] = 1'b0; tick();
    #1; chk("drain_count", count, 3);
    e_valid[7] = 1'b0; alloc_req = 1'b1;
    #1; chk("simul3_id", alloc_id, 2);
    tick();
    #1; chk("simul3_count", count, 3);
    tick(); tick();
    #1; chk("pre_rst_count", count, 5);

    // Asynchronous reset between edges, with a request still pending.
    #1;
    reset = 1'b1; hd = 0; tl = 0; e_valid = '0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_e_alloc", e_alloc, 0);
    chk("arst_gnt", alloc_gnt, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("restart_id", alloc_id, 0);
    chk("restart_gnt", alloc_gnt, 1);
    tick(); tick();
    alloc_req = 1'b0;
    #1; chk("restart_count", count, 2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
